uart_cmd_parser: RTL and testbench

//  Frame controller behind UART_RX: consumes the o_RX_DV/o_RX_Byte stream and parses command frames.

---
 rtl/uart_cmd_parser_pkg.sv | 25 ++
 rtl/uart_cmd_parser_timeout.sv | 41 ++++
 rtl/uart_cmd_parser.sv | 168 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command-frame parser.
//   state_e          : parser FSM states
//   DefaultSyncByte  : default frame start marker
//   ByteW / LenW     : byte width and width of the LEN field / payload index
//   csum_add         : modulo-256 checksum accumulate
package uart_cmd_parser_pkg;

  localparam int unsigned ByteW           = 8;
  localparam int unsigned LenW            = 5;
  localparam logic [7:0]  DefaultSyncByte = 8'hA5;

  typedef enum logic [2:0] {
    StHunt = 3'd0,
    StCmd  = 3'd1,
    StLen  = 3'd2,
    StData = 3'd3,
    StCsum = 3'd4
  } state_e;

  function automatic logic [ByteW-1:0] csum_add(input logic [ByteW-1:0] acc,
                                                input logic [ByteW-1:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte timeout counter for the command parser.
//   i_Clock, i_Rst_n : clock, asynchronous active-low reset
//   i_Clear          : restart the count (a byte arrived)
//   i_Enable         : count while a frame is in progress; held at 0 otherwise
//   o_Expire         : count reached TIMEOUT_CLKS-1 with no clear this cycle
module uart_cmd_parser_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 20000
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expire
);

  localparam int unsigned CntW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CLKS - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_Clear || !i_Enable) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  // A clear in the expiry cycle means a byte arrived in time.
  assign o_Expire = i_Enable && !i_Clear && (count_q == CntLast);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Command-frame parser behind UART_RX: SYNC | CMD | LEN | DATA[LEN] | CSUM.
// Validates length and 8-bit checksum, enforces an inter-byte timeout and
// presents the last good command to the motor/config logic.
//   i_Clock, i_Rst_n      : clock, asynchronous active-low reset
//   i_RX_DV, i_RX_Byte    : byte stream from UART_RX
//   o_Cmd_Valid           : 1-cycle pulse, new good frame latched
//   o_Cmd_ID/Len/Data     : fields of the last good frame (data byte k at [8k+7:8k])
//   o_Csum_Err/o_Len_Err/o_Timeout_Err : 1-cycle error pulses
//   o_Busy                : a frame is in progress
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = DefaultSyncByte,
  parameter int unsigned MAX_LEN      = 8,
  parameter int unsigned TIMEOUT_CLKS = 20000
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_n,
  input  logic                       i_RX_DV,
  input  logic [ByteW-1:0]           i_RX_Byte,
  output logic                       o_Cmd_Valid,
  output logic [ByteW-1:0]           o_Cmd_ID,
  output logic [LenW-1:0]            o_Cmd_Len,
  output logic [ByteW*MAX_LEN-1:0]   o_Cmd_Data,
  output logic                       o_Csum_Err,
  output logic                       o_Len_Err,
  output logic                       o_Timeout_Err,
  output logic                       o_Busy
);

  state_e                          state_q, state_d;
  logic [ByteW-1:0]                sum_q, sum_d;
  logic [ByteW-1:0]                id_q, id_d;
  logic [LenW-1:0]                 len_q, len_d;
  logic [LenW-1:0]                 idx_q, idx_d;
  logic [MAX_LEN-1:0][ByteW-1:0]   stage_q, stage_d;

  logic                            cmd_valid_q, cmd_valid_d;
  logic                            csum_err_q, csum_err_d;
  logic                            len_err_q, len_err_d;
  logic                            tout_err_q, tout_err_d;
  logic [ByteW-1:0]                cmd_id_q, cmd_id_d;
  logic [LenW-1:0]                 cmd_len_q, cmd_len_d;
  logic [ByteW*MAX_LEN-1:0]        cmd_data_q, cmd_data_d;

  logic                            expire;

  uart_cmd_parser_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock  (i_Clock),
    .i_Rst_n  (i_Rst_n),
    .i_Clear  (i_RX_DV),
    .i_Enable (state_q != StHunt),
    .o_Expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    id_d        = id_q;
    len_d       = len_q;
    idx_d       = idx_q;
    stage_d     = stage_q;
    cmd_valid_d = 1'b0;
    csum_err_d  = 1'b0;
    len_err_d   = 1'b0;
    tout_err_d  = 1'b0;
    cmd_id_d    = cmd_id_q;
    cmd_len_d   = cmd_len_q;
    cmd_data_d  = cmd_data_q;

    // A byte always takes priority over a simultaneous timeout.
    if (i_RX_DV) begin
      unique case (state_q)
        StHunt: begin
          if (i_RX_Byte == SYNC_BYTE) state_d = StCmd;
        end
        StCmd: begin
          id_d    = i_RX_Byte;
          sum_d   = i_RX_Byte;
          state_d = StLen;
        end
        StLen: begin
          sum_d = csum_add(sum_q, i_RX_Byte);
          len_d = i_RX_Byte[LenW-1:0];
          idx_d = '0;
          if (i_RX_Byte > ByteW'(MAX_LEN)) begin
            len_err_d = 1'b1;
            state_d   = StHunt;
          end else if (i_RX_Byte == '0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          for (int k = 0; k < MAX_LEN; k++) begin
            if (idx_q == LenW'(k)) stage_d[k] = i_RX_Byte;
          end
          sum_d = csum_add(sum_q, i_RX_Byte);
          idx_d = idx_q + 1'b1;
          if (idx_q == len_q - 1'b1) state_d = StCsum;
        end
        StCsum: begin
          if (i_RX_Byte == sum_q) begin
            cmd_valid_d = 1'b1;
            cmd_id_d    = id_q;
            cmd_len_d   = len_q;
            // Staging may hold bytes from an older, longer frame; mask them.
            for (int k = 0; k < MAX_LEN; k++) begin
              cmd_data_d[ByteW*k +: ByteW] = (LenW'(k) < len_q) ? stage_q[k] : '0;
            end
          end else begin
            csum_err_d = 1'b1;
          end
          state_d = StHunt;
        end
        default: state_d = StHunt;
      endcase
    end else if (expire) begin
      tout_err_d = 1'b1;
      state_d    = StHunt;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= StHunt;
      sum_q       <= '0;
      id_q        <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      stage_q     <= '0;
      cmd_valid_q <= 1'b0;
      csum_err_q  <= 1'b0;
      len_err_q   <= 1'b0;
      tout_err_q  <= 1'b0;
      cmd_id_q    <= '0;
      cmd_len_q   <= '0;
      cmd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      id_q        <= id_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      stage_q     <= stage_d;
      cmd_valid_q <= cmd_valid_d;
      csum_err_q  <= csum_err_d;
      len_err_q   <= len_err_d;
      tout_err_q  <= tout_err_d;
      cmd_id_q    <= cmd_id_d;
      cmd_len_q   <= cmd_len_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  assign o_Cmd_Valid   = cmd_valid_q;
  assign o_Cmd_ID      = cmd_id_q;
  assign o_Cmd_Len     = cmd_len_q;
  assign o_Cmd_Data    = cmd_data_q;
  assign o_Csum_Err    = csum_err_q;
  assign o_Len_Err     = len_err_q;
  assign o_Timeout_Err = tout_err_q;
  assign o_Busy        = (state_q != StHunt);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected events are queued as frames are
// driven and checked when the DUT pulses Valid or an error.
module tb_uart_cmd_parser;

  localparam int unsigned MaxLen = 8;
  localparam int unsigned Tout   = 50;
  localparam logic [7:0]  Sync   = 8'hA5;

  logic              clk;
  logic              rst_n;
  logic              dv;
  logic [7:0]        rx_byte;
  logic              cmd_valid;
  logic [7:0]        cmd_id;
  logic [4:0]        cmd_len;
  logic [8*MaxLen-1:0] cmd_data;
  logic              csum_err;
  logic              len_err;
  logic              tout_err;
  logic              busy;

  uart_cmd_parser #(
    .SYNC_BYTE    (Sync),
    .MAX_LEN      (MaxLen),
    .TIMEOUT_CLKS (Tout)
  ) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_RX_DV       (dv),
    .i_RX_Byte     (rx_byte),
    .o_Cmd_Valid   (cmd_valid),
    .o_Cmd_ID      (cmd_id),
    .o_Cmd_Len     (cmd_len),
    .o_Cmd_Data    (cmd_data),
    .o_Csum_Err    (csum_err),
    .o_Len_Err     (len_err),
    .o_Timeout_Err (tout_err),
    .o_Busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // pulses = {valid, csum_err, len_err, timeout_err}
  typedef struct {
    logic [3:0]  pulses;
    logic [7:0]  id;
    logic [4:0]  len;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  good_id   = '0;
  logic [4:0]  good_len  = '0;
  logic [63:0] good_data = '0;

  task automatic expect_evt(input logic [3:0] p, input int due);
    exp_t e;
    e.pulses = p;
    e.id     = good_id;
    e.len    = good_len;
    e.data   = good_data;
    e.due    = due;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] obs;
    if (rst_n) begin
      obs = {cmd_valid, csum_err, len_err, tout_err};
      if (obs != 4'b0000) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_pulse", 64'(obs), 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("pulses", 64'(obs), 64'(e.pulses));
          check_eq("latency", 64'(cyc), 64'(e.due));
          check_eq("cmd_id", 64'(cmd_id), 64'(e.id));
          check_eq("cmd_len", 64'(cmd_len), 64'(e.len));
          check_eq("cmd_data", cmd_data, e.data);
          check_eq("busy_at_pulse", 64'(busy), 64'd0);
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        check_eq("missing_pulse", 64'd0, 64'(e.pulses));
      end
    end
  end

  // Called on a negedge; byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    dv      = 1'b1;
    rx_byte = b;
    @(negedge clk);
    dv      = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] len,
                            input logic [127:0] pl, input bit bad);
    logic [7:0]  s;
    logic [63:0] d;
    send_byte(Sync);
    send_byte(id);
    s = id;
    send_byte(len);
    s = s + len;
    d = '0;
    for (int k = 0; k < int'(len); k++) begin
      send_byte(pl[8*k +: 8]);
      s = s + pl[8*k +: 8];
      if (k < int'(MaxLen)) d[8*k +: 8] = pl[8*k +: 8];
    end
    if (bad) begin
      s = s + 8'h01;
      expect_evt(4'b0100, cyc + 1);
    end else begin
      good_id   = id;
      good_len  = len[4:0];
      good_data = d;
      expect_evt(4'b1000, cyc + 1);
    end
    send_byte(s);
  endtask

  initial begin
    rst_n   = 1'b0;
    dv      = 1'b0;
    rx_byte = 8'h00;
    idle(3);
    check_eq("rst_pulses", 64'({cmd_valid, csum_err, len_err, tout_err}), 64'd0);
    check_eq("rst_id_len", 64'({cmd_id, cmd_len}), 64'd0);
    check_eq("rst_data", cmd_data, 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Good frame A5 10 02 34 56 9C
    send_frame(8'h10, 8'd2, 128'h5634, 1'b0);
    // Same frame, bad checksum: outputs must hold
    send_frame(8'h10, 8'd2, 128'h5634, 1'b1);

    // Length error after LEN byte, then zero-length frame back-to-back
    send_byte(Sync);
    send_byte(8'h01);
    expect_evt(4'b0010, cyc + 1);
    send_byte(8'h09);
    send_frame(8'h01, 8'd0, 128'h0, 1'b0);

    // Max length, then shorter frame: stale staging bytes must read 0
    send_frame(8'h33, 8'd8, 128'h0807060504030201, 1'b0);
    send_frame(8'h44, 8'd3, 128'hCCBBAA, 1'b0);

    // Garbage before a frame; SYNC value inside the payload
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA4);
    send_frame(8'h07, 8'd1, 128'hA5, 1'b0);
    idle(3);

    // Silence mid-frame -> one timeout pulse
    send_byte(Sync);
    send_byte(8'h20);
    expect_evt(4'b0001, cyc + Tout);
    idle(Tout + 5);
    check_eq("busy_after_timeout", 64'(busy), 64'd0);

    // Bytes landing exactly on the expiry cycle win
    send_byte(Sync);
    idle(Tout - 1);
    send_byte(8'h01);
    idle(Tout - 1);
    send_byte(8'h00);
    idle(Tout - 1);
    good_id   = 8'h01;
    good_len  = 5'd0;
    good_data = '0;
    expect_evt(4'b1000, cyc + 1);
    send_byte(8'h01);
    idle(3);

    // Reset while in DATA clears outputs asynchronously
    send_frame(8'h5A, 8'd2, 128'h1357, 1'b0);
    send_byte(Sync);
    send_byte(8'h55);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    check_eq("busy_in_data", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_id_len", 64'({cmd_id, cmd_len}), 64'd0);
    check_eq("async_rst_data", cmd_data, 64'd0);
    check_eq("async_rst_busy", 64'(busy), 64'd0);
    good_id   = '0;
    good_len  = '0;
    good_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_frame(8'h66, 8'd1, 128'h77, 1'b0);

    begin
      int w = 0;
      while (sb.size() != 0 && w < 200) begin
        @(negedge clk);
        w++;
      end
    end
    idle(3);
    check_eq("sb_drain", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
